reg_bus_initiator: RTL and testbench

Command-driven initiator for the single-cycle register bus (wr_en/rd_en/addr/wdata/rdata) used by counter_top and its sibling register blocks. It accepts write, read and poll commands over a valid/ready interface and turns each one into correctly timed bus strobes. It returns one response per command over a second valid/ready interface. It sits between a sequencer or CPU-side shim and a register-mapped peripheral, and replaces hand-timed bench tasks in system-level integration.

---
 rtl/reg_bus_initiator.sv | 202 ++++++++++++++++++++
 tb/tb_reg_bus_initiator.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bus_initiator.sv
// Command-driven initiator for the single-cycle register bus: turns write/read/poll
// commands into registered bus strobes and returns one response per command.
module reg_bus_initiator #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int POLL_MAX = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [DATA_W-1:0] cmd_mask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              busy,
  output logic              wr_en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata
);

  localparam int CNT_W = $clog2(POLL_MAX + 1);
  localparam logic [CNT_W-1:0] ATT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ATT_LAST = CNT_W'(POLL_MAX);

  localparam logic [1:0] OP_WR   = 2'b00;
  localparam logic [1:0] OP_RD   = 2'b01;
  localparam logic [1:0] OP_POLL = 2'b10;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD   = 3'd2,
    POLL = 3'd3,
    RESP = 3'd4
  } state_t;

  state_t             state_r, state_s;
  logic [ADDR_W-1:0]  addr_lat_r, addr_lat_s;
  logic [DATA_W-1:0]  wdata_lat_r, wdata_lat_s;
  logic [DATA_W-1:0]  mask_r, mask_s;
  logic [CNT_W-1:0]   attempt_r, attempt_s;
  logic               wr_en_r, wr_en_s;
  logic               rd_en_r, rd_en_s;
  logic [ADDR_W-1:0]  addr_r, addr_s;
  logic [DATA_W-1:0]  wdata_r, wdata_s;
  logic               rsp_valid_r, rsp_valid_s;
  logic [DATA_W-1:0]  rsp_data_r, rsp_data_s;
  logic               rsp_err_r, rsp_err_s;
  logic               poll_hit_s;

  assign cmd_ready = (state_r == IDLE) & ~rst;
  assign busy      = (state_r != IDLE);
  assign wr_en     = wr_en_r;
  assign rd_en     = rd_en_r;
  assign addr      = addr_r;
  assign wdata     = wdata_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_err   = rsp_err_r;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state plus next values of every registered output; strobes default low.
  always_comb begin
    state_s     = state_r;
    addr_lat_s  = addr_lat_r;
    wdata_lat_s = wdata_lat_r;
    mask_s      = mask_r;
    attempt_s   = attempt_r;
    wr_en_s     = 1'b0;
    rd_en_s     = 1'b0;
    addr_s      = '0;
    wdata_s     = '0;
    rsp_valid_s = rsp_valid_r;
    rsp_data_s  = rsp_data_r;
    rsp_err_s   = rsp_err_r;
    poll_hit_s  = ((rdata & mask_r) == (wdata_lat_r & mask_r));
    case (state_r)
      IDLE: begin
        if (cmd_valid) begin
          addr_lat_s  = cmd_addr;
          wdata_lat_s = cmd_wdata;
          mask_s      = cmd_mask;
          case (cmd_op)
            OP_WR: begin
              state_s = WR;
              wr_en_s = 1'b1;
              addr_s  = cmd_addr;
              wdata_s = cmd_wdata;
            end
            OP_RD: begin
              state_s = RD;
              rd_en_s = 1'b1;
              addr_s  = cmd_addr;
            end
            OP_POLL: begin
              state_s   = POLL;
              rd_en_s   = 1'b1;
              addr_s    = cmd_addr;
              attempt_s = ATT_ONE;
            end
            default: begin
              state_s     = RESP;
              rsp_valid_s = 1'b1;
              rsp_data_s  = '0;
              rsp_err_s   = 1'b1;
            end
          endcase
        end else begin
          state_s = IDLE;
        end
      end
      WR: begin
        state_s     = RESP;
        rsp_valid_s = 1'b1;
        rsp_data_s  = '0;
        rsp_err_s   = 1'b0;
      end
      RD: begin
        state_s     = RESP;
        rsp_valid_s = 1'b1;
        rsp_data_s  = rdata;
        rsp_err_s   = 1'b0;
      end
      POLL: begin
        // A hit on the last attempt still wins over the timeout.
        if (poll_hit_s) begin
          state_s     = RESP;
          rsp_valid_s = 1'b1;
          rsp_data_s  = rdata;
          rsp_err_s   = 1'b0;
        end else if (attempt_r == ATT_LAST) begin
          state_s     = RESP;
          rsp_valid_s = 1'b1;
          rsp_data_s  = rdata;
          rsp_err_s   = 1'b1;
        end else begin
          attempt_s = attempt_r + ATT_ONE;
          rd_en_s   = 1'b1;
          addr_s    = addr_lat_r;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_s     = IDLE;
          rsp_valid_s = 1'b0;
          rsp_data_s  = '0;
          rsp_err_s   = 1'b0;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Output and command-latch registers; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_lat_r  <= '0;
      wdata_lat_r <= '0;
      mask_r      <= '0;
      attempt_r   <= '0;
      wr_en_r     <= 1'b0;
      rd_en_r     <= 1'b0;
      addr_r      <= '0;
      wdata_r     <= '0;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= '0;
      rsp_err_r   <= 1'b0;
    end else begin
      addr_lat_r  <= addr_lat_s;
      wdata_lat_r <= wdata_lat_s;
      mask_r      <= mask_s;
      attempt_r   <= attempt_s;
      wr_en_r     <= wr_en_s;
      rd_en_r     <= rd_en_s;
      addr_r      <= addr_s;
      wdata_r     <= wdata_s;
      rsp_valid_r <= rsp_valid_s;
      rsp_data_r  <= rsp_data_s;
      rsp_err_r   <= rsp_err_s;
    end
  end

endmodule

// File: tb/tb_reg_bus_initiator.sv
// Scoreboard bench for reg_bus_initiator with a small register-slave model
// (constant source or free-running counter enabled by CTRL bit 0 at 0x000).
module tb_reg_bus_initiator;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [9:0]  cmd_addr = 10'h000;
  logic [31:0] cmd_wdata = 32'h0;
  logic [31:0] cmd_mask = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        busy;
  logic        wr_en, rd_en;
  logic [9:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  logic        model_mode = 1'b0;
  logic [31:0] const_val = 32'h0;
  logic        cnt_clr = 1'b0;
  logic [31:0] count;
  logic        ctrl_en;

  int wr_cnt = 0, rd_cnt = 0, both_cnt = 0, rsp_seen = 0, cyc = 0;
  int n_checks = 0, n_fail = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  reg_bus_initiator #(.ADDR_W(10), .DATA_W(32), .POLL_MAX(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy),
    .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wdata(wdata), .rdata(rdata)
  );

  always_comb rdata = model_mode ? count : const_val;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (wr_en) wr_cnt <= wr_cnt + 1;
    if (rd_en) rd_cnt <= rd_cnt + 1;
    if (wr_en && rd_en) both_cnt <= both_cnt + 1;
    if (rsp_valid) rsp_seen <= rsp_seen + 1;
    if (rst) begin
      ctrl_en <= 1'b0;
      count   <= 32'h0;
    end else begin
      if (wr_en && addr == 10'h000) ctrl_en <= wdata[0];
      if (cnt_clr) count <= 32'h0000_000C;
      else if (ctrl_en) count <= count + 32'd1;
    end
  end

  // Drive one command starting at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic [1:0] op, input logic [9:0] a, input logic [31:0] d,
                       input logic [31:0] m);
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL issue_ready: cmd_ready=%b want 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = d; cmd_mask = m;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = 10'h000; cmd_wdata = 32'h0; cmd_mask = 32'h0;
  endtask

  // Wait (bounded) for the response, compare against the scoreboard, then consume it.
  task automatic complete_rsp(input string name, input int exp_lat);
    int lat;
    exp_t e;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (rsp_valid !== 1'b1) begin
      n_fail++; $display("FAIL %s_timeout: no rsp_valid within 40 cycles", name);
      if (sb.size() > 0) e = sb.pop_front();
      return;
    end
    n_checks++;
    if (lat != exp_lat) begin
      n_fail++; $display("FAIL %s_latency: got %0d want %0d", name, lat, exp_lat);
    end
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++; $display("FAIL %s_unexpected: response with empty scoreboard", name);
    end else begin
      e = sb.pop_front();
      if (rsp_data !== e.data || rsp_err !== e.err) begin
        n_fail++;
        $display("FAIL %s_rsp: got data=%h err=%b want data=%h err=%b",
                 name, rsp_data, rsp_err, e.data, e.err);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s_release: rsp_valid=%b cmd_ready=%b want 0/1", name, rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({wr_en, rd_en, rsp_valid, rsp_err, busy, cmd_ready} !== 6'b0 ||
        addr !== 10'h0 || wdata !== 32'h0 || rsp_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: wr=%b rd=%b rv=%b re=%b busy=%b crdy=%b addr=%h wd=%h rd=%h want all 0",
               wr_en, rd_en, rsp_valid, rsp_err, busy, cmd_ready, addr, wdata, rsp_data);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: cmd_ready=%b busy=%b want 1/0", cmd_ready, busy);
    end
  endtask

  task automatic test_write();
    int w0;
    w0 = wr_cnt;
    sb.push_back('{data: 32'h0, err: 1'b0});
    issue(2'b00, 10'h000, 32'h1, 32'h0);
    n_checks++;
    if (wr_en !== 1'b1 || rd_en !== 1'b0 || addr !== 10'h000 || wdata !== 32'h1) begin
      n_fail++;
      $display("FAIL write_strobe: wr=%b rd=%b addr=%h wdata=%h want 1/0/000/00000001", wr_en, rd_en, addr, wdata);
    end
    complete_rsp("write", 1);
    n_checks++;
    if (wr_cnt - w0 != 1) begin
      n_fail++; $display("FAIL write_count: got %0d wr_en cycles want 1", wr_cnt - w0);
    end
  endtask

  task automatic test_read();
    int r0;
    model_mode = 1'b0; const_val = 32'h0000_00A5;
    r0 = rd_cnt;
    sb.push_back('{data: 32'h0000_00A5, err: 1'b0});
    issue(2'b01, 10'h004, 32'h0, 32'h0);
    n_checks++;
    if (rd_en !== 1'b1 || wr_en !== 1'b0 || addr !== 10'h004 || wdata !== 32'h0) begin
      n_fail++; $display("FAIL read_strobe: rd=%b wr=%b addr=%h wdata=%h want 1/0/004/0", rd_en, wr_en, addr, wdata);
    end
    complete_rsp("read", 1);
    n_checks++;
    if (rd_cnt - r0 != 1) begin
      n_fail++; $display("FAIL read_count: got %0d rd_en cycles want 1", rd_cnt - r0);
    end
  endtask

  // Poll the live counter (reloaded to 0x0C); target 0x10 hits early, 0x14 on the last attempt.
  task automatic test_poll_counter(input logic [31:0] target, input int exp_att);
    int r0;
    logic [31:0] first_val;
    model_mode = 1'b1;
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    r0 = rd_cnt;
    sb.push_back('{data: target, err: 1'b0});
    issue(2'b10, 10'h004, target, 32'h0000_00FF);
    first_val = rdata;
    complete_rsp("poll_counter", exp_att);
    n_checks++;
    if (rd_cnt - r0 != int'(target - first_val) + 1) begin
      n_fail++;
      $display("FAIL poll_counter_count: got %0d rd_en cycles want %0d", rd_cnt - r0, int'(target - first_val) + 1);
    end
  endtask

  task automatic test_poll_timeout();
    int r0;
    model_mode = 1'b0; const_val = 32'h0000_0005;
    r0 = rd_cnt;
    sb.push_back('{data: 32'h0000_0005, err: 1'b1});
    issue(2'b10, 10'h004, 32'h0000_0007, 32'h0000_00FF);
    complete_rsp("poll_timeout", 8);
    n_checks++;
    if (rd_cnt - r0 != 8) begin
      n_fail++; $display("FAIL poll_timeout_count: got %0d rd_en cycles want 8", rd_cnt - r0);
    end
  endtask

  task automatic test_poll_mask();
    model_mode = 1'b0; const_val = 32'h0000_0035;
    sb.push_back('{data: 32'h0000_0035, err: 1'b0});
    issue(2'b10, 10'h008, 32'h0000_00F5, 32'h0000_000F);
    complete_rsp("poll_mask", 1);
  endtask

  task automatic test_rsp_stall();
    int s0;
    model_mode = 1'b0; const_val = 32'h0000_003C;
    sb.push_back('{data: 32'h0000_003C, err: 1'b0});
    issue(2'b01, 10'h00C, 32'h0, 32'h0);
    @(negedge clk);
    const_val = 32'hFFFF_FFFF;
    s0 = wr_cnt + rd_cnt;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'h0000_003C || rsp_err !== 1'b0 ||
          cmd_ready !== 1'b0 || wr_en !== 1'b0 || rd_en !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold_%0d: rv=%b data=%h err=%b crdy=%b wr=%b rd=%b want 1/0000003c/0/0/0/0",
                 i, rsp_valid, rsp_data, rsp_err, cmd_ready, wr_en, rd_en);
      end
      @(negedge clk);
    end
    complete_rsp("stall", 0);
    sb.push_back('{data: 32'h0, err: 1'b1});
    issue(2'b11, 10'h123, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
    complete_rsp("reserved", 0);
    n_checks++;
    if (wr_cnt + rd_cnt != s0) begin
      n_fail++; $display("FAIL reserved_strobes: got %0d strobes want 0", wr_cnt + rd_cnt - s0);
    end
  endtask

  task automatic test_back_to_back();
    int c0;
    c0 = cyc;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{data: 32'h0, err: 1'b0});
      issue(2'b00, 10'h010, 32'(i + 1), 32'h0);
      complete_rsp("b2b_write", 1);
    end
    n_checks++;
    if (cyc - c0 != 9) begin
      n_fail++; $display("FAIL b2b_throughput: got %0d cycles for 3 writes want 9", cyc - c0);
    end
  endtask

  task automatic test_reset_mid_poll();
    int r0, v0;
    model_mode = 1'b0; const_val = 32'h0000_0005;
    r0 = rd_cnt;
    v0 = rsp_seen;
    issue(2'b10, 10'h004, 32'h0000_0007, 32'h0000_00FF);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (rd_en !== 1'b0 || wr_en !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL midpoll_reset: rd=%b wr=%b rv=%b busy=%b want 0", rd_en, wr_en, rsp_valid, busy);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL midpoll_ready: cmd_ready=%b want 1", cmd_ready);
    end
    repeat (12) @(negedge clk);
    n_checks++;
    if (rd_cnt - r0 != 3 || rsp_seen != v0) begin
      n_fail++;
      $display("FAIL midpoll_discard: rd cycles=%0d rsp cycles=%0d want 3/0", rd_cnt - r0, rsp_seen - v0);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_poll_counter(32'h0000_0010, 4);
    test_poll_counter(32'h0000_0014, 8);
    test_poll_timeout();
    test_poll_mask();
    test_rsp_stall();
    test_back_to_back();
    test_reset_mid_poll();
    n_checks++;
    if (both_cnt != 0 || sb.size() != 0) begin
      n_fail++; $display("FAIL final_state: both-strobe cycles=%0d pending=%0d want 0/0", both_cnt, sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
